// File: rtl/data_store_buffer_pkg.sv
// Shared definitions for the posted-store write buffer: entry width helper,
// access-type encoding and the word-address slice macro.
`ifndef DATA_STORE_BUFFER_PKG_SV
`define DATA_STORE_BUFFER_PKG_SV

// Word address of a byte address signal: drops the two byte-select bits.
`define DSB_WORD_ADDR(a, w) a[(w)-1:2]

package data_store_buffer_pkg;

    // Width of one buffered entry: word address plus data word.
    function automatic int wb_entry_w(input int addr_w, input int data_w);
        return addr_w - 2 + data_w;
    endfunction

    // Entry width for the default 32-bit address / 32-bit data build.
    localparam int WB_ENTRY = wb_entry_w(32, 32);

    // Meaning of cpu_wrn when cpu_ce is high.
    typedef enum logic {
        ACC_LOAD  = 1'b0,
        ACC_STORE = 1'b1
    } acc_t;

endpackage

`endif

// File: rtl/data_store_buffer_fwd_match.sv
// ds_fwd_match: combinational youngest-first address search over the
// buffer entries. The search order starts at the entry just behind the
// tail pointer (youngest) and walks backward towards the oldest entry.
module ds_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int AW     = 30,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [AW-1:0]     entry_addr [DEPTH],
    input  logic [DATA_W-1:0] entry_data [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    input  logic [PTR_W-1:0]  tail,
    input  logic [AW-1:0]     lookup,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    // ord_idx[k] is the entry k+1 places behind the tail (k=0 is youngest)
    logic [PTR_W-1:0] ord_idx [DEPTH];
    logic [DEPTH-1:0] ord_hit;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_order
            assign ord_idx[gi] = tail - PTR_W'(gi + 1);
            assign ord_hit[gi] = valid[ord_idx[gi]] &&
                                 (entry_addr[ord_idx[gi]] == lookup);
        end
    endgenerate

    // Priority select: scan oldest to youngest so the youngest hit wins
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ord_hit[i]) begin
                hit  = 1'b1;
                data = entry_data[ord_idx[i]];
            end
        end
    end

endmodule

// File: rtl/data_store_buffer.sv
// data_store_buffer: posted-store FIFO between the CPU data port and a
// single-port data RAM. Stores retire into the buffer, drain when the RAM
// port is idle, and loads are forwarded from the youngest matching entry.
// Optional feature macro: STORE_COALESCE_EN (store to the tail entry's word
// address overwrites that entry in place instead of enqueueing).
module data_store_buffer
    import data_store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_ce,
    input  logic              cpu_wrn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wrdata,
    output logic [DATA_W-1:0] cpu_rddata,
    output logic              stall_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_busy,
    output logic              wb_empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int AW      = ADDR_W - 2;
    localparam int ENTRY_W = wb_entry_w(ADDR_W, DATA_W);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0]    count_reg, count_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [ENTRY_W-1:0] entry_mem [DEPTH];

    logic [AW-1:0]     ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  valid;

    acc_t              acc_type;
    logic              is_load, is_store, full, drain, enq, coalesce;
    logic [PTR_W-1:0]  tail_idx;
    logic [AW-1:0]     word_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign acc_type  = acc_t'(cpu_wrn);
    assign is_load   = cpu_ce & (acc_type == ACC_LOAD);
    assign is_store  = cpu_ce & (acc_type == ACC_STORE);
    assign full      = (count_reg == FULL_COUNT);
    assign tail_idx  = wr_ptr_reg - PTR_W'(1);
    assign word_addr = `DSB_WORD_ADDR(cpu_addr, ADDR_W);

    // A load owns the RAM port; during reset nothing is written so that
    // discarded entries never reach memory.
    assign drain = ~reset & (count_reg != '0) & ~ram_busy & ~is_load;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] age;
            assign ent_addr[gi] = entry_mem[gi][ENTRY_W-1:DATA_W];
            assign ent_data[gi] = entry_mem[gi][DATA_W-1:0];
            // entry is live when it lies within count slots of the head
            assign age       = PTR_W'(gi) - rd_ptr_reg;
            assign valid[gi] = ({1'b0, age} < count_reg);
        end
    endgenerate

    ds_fwd_match #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_load_match (
        .entry_addr (ent_addr),
        .entry_data (ent_data),
        .valid      (valid),
        .tail       (wr_ptr_reg),
        .lookup     (word_addr),
        .hit        (fwd_hit),
        .data       (fwd_data)
    );

`ifdef STORE_COALESCE_EN
    logic [DEPTH-1:0]  tail_valid;
    logic              tail_hit;
    logic [DATA_W-1:0] tail_data;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tail_mask
            assign tail_valid[gi] = valid[gi] & (PTR_W'(gi) == tail_idx);
        end
    endgenerate

    ds_fwd_match #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_tail_match (
        .entry_addr (ent_addr),
        .entry_data (ent_data),
        .valid      (tail_valid),
        .tail       (wr_ptr_reg),
        .lookup     (word_addr),
        .hit        (tail_hit),
        .data       (tail_data)
    );

    // The single remaining entry leaving this cycle cannot absorb a store
    assign coalesce = is_store & tail_hit &
                      ~(drain & (count_reg == (PTR_W + 1)'(1)));
`else
    assign coalesce = 1'b0;
`endif

    // A full buffer stalls even if it drains this cycle
    assign enq       = is_store & ~full & ~coalesce;
    assign stall_req = is_store & full & ~coalesce;

    assign ram_we     = drain;
    assign ram_addr   = drain ? {ent_addr[rd_ptr_reg], 2'b00} : cpu_addr;
    assign ram_wdata  = ent_data[rd_ptr_reg];
    assign cpu_rddata = (is_load & fwd_hit) ? fwd_data : ram_rdata;
    assign wb_empty   = (count_reg == '0);

    // Next-state for occupancy and pointers
    always_comb begin
        rd_ptr_next = rd_ptr_reg + (drain ? PTR_W'(1) : PTR_W'(0));
        wr_ptr_next = wr_ptr_reg + (enq ? PTR_W'(1) : PTR_W'(0));
        count_next  = count_reg;
        if (enq && !drain) begin
            count_next = count_reg + (PTR_W + 1)'(1);
        end else if (!enq && drain) begin
            count_next = count_reg - (PTR_W + 1)'(1);
        end
    end

    // Occupancy and pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    // Entry storage: enqueue at the tail or overwrite the tail's data
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (enq) begin
                entry_mem[wr_ptr_reg] <= {word_addr, cpu_wrdata};
            end else if (coalesce) begin
                entry_mem[tail_idx][DATA_W-1:0] <= cpu_wrdata;
            end
        end
    end

endmodule
